game_sequencer: RTL

//  Parametrised top-level game FSM: start handshake, screen clear, per-frame update, draw sequencing

---
 rtl/game_pkg.sv | 26 ++
 rtl/game_sequencer_frame_timer.sv | 30 +++
 rtl/game_sequencer.sv | 137 +++++++++++++
 3 files changed

// File: rtl/game_pkg.sv
// Shared definitions for the game sequencer, its datapath and its bench:
// state encoding, the 60 Hz frame length at 50 MHz, and a layer-index width helper.
package game_pkg;

  localparam int STATE_W = 4;

  typedef enum logic [STATE_W-1:0] {
    S_IDLE   = 4'd0,
    S_ARM    = 4'd1,
    S_CLEAR  = 4'd2,
    S_UPDATE = 4'd3,
    S_DRAW   = 4'd4,
    S_WAIT   = 4'd5,
    S_PAUSE  = 4'd6,
    S_END    = 4'd7
  } state_t;

  // 50 MHz / 60 Hz, rounded down
  localparam int FRAME_TICKS_60HZ = 833333;

  // Width of a layer index; never narrower than one bit
  function automatic int layer_w(input int n_layers);
    return (n_layers > 1) ? $clog2(n_layers) : 1;
  endfunction

endpackage

// File: rtl/game_sequencer_frame_timer.sv
// Saturating frame timer. Counts clock cycles since the last frame update and
// sticks at FRAME_TICKS-1, which is reported as the terminal count.
module frame_timer #(
  parameter int TICK_W      = 20,
  parameter int FRAME_TICKS = 833333
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              clear,
  input  logic              enable,
  output logic [TICK_W-1:0] tick,
  output logic              terminal
);

  localparam logic [TICK_W-1:0] LAST_TICK = TICK_W'(FRAME_TICKS - 1);

  assign terminal = (tick == LAST_TICK);

  // Clear wins over counting; counting stops at the terminal value
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      tick <= '0;
    end else if (clear) begin
      tick <= '0;
    end else if (enable && !terminal) begin
      tick <= tick + TICK_W'(1);
    end
  end

endmodule

// File: rtl/game_sequencer.sv
// Top-level game FSM: start handshake, screen clear, per-frame update, layered
// draw sequencing, pause/resume, game over and restart. Drives the datapath
// update strobe and the VGA plotter enables.
//
// Input contract: start is a level that must be pressed then released to begin
// or restart a game; pause_req, clear_done and draw_done are single-cycle
// pulses acted on only in the state that waits for them (a level held high in
// S_DRAW advances one layer per cycle); finish_game is looked at only in S_UPDATE.
module game_sequencer
  import game_pkg::*;
#(
  parameter  int N_LAYERS    = 2,
  parameter  int TICK_W      = 20,
  parameter  int FRAME_TICKS = FRAME_TICKS_60HZ,
  parameter  int FRAME_W     = 16,
  localparam int LSW         = layer_w(N_LAYERS)
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                start,
  input  logic                pause_req,
  input  logic                finish_game,
  input  logic                clear_done,
  input  logic                draw_done,
  output logic                update,
  output logic                plot,
  output logic                clear,
  output logic [LSW-1:0]      layer_sel,
  output logic [N_LAYERS-1:0] draw_layer,
  output logic                paused,
  output logic                game_over,
  output logic                overrun,
  output logic [FRAME_W-1:0]  frame_count,
  output logic [STATE_W-1:0]  state_dbg,
  output logic [TICK_W-1:0]   tick_dbg
);

  localparam logic [LSW-1:0] LAST_LAYER = LSW'(N_LAYERS - 1);

  state_t state;
  logic   timer_clear;
  logic   timer_en;
  logic   terminal;
  logic   last_layer;

  assign last_layer = (layer_sel == LAST_LAYER);

  // Timer runs while a frame is live; it restarts on every transition into S_UPDATE
  always_comb begin
    timer_en    = (state == S_UPDATE) || (state == S_DRAW) || (state == S_WAIT);
    timer_clear = 1'b0;
    case (state)
      S_CLEAR: timer_clear = clear_done;
      S_DRAW:  timer_clear = draw_done && last_layer && terminal;
      S_WAIT:  timer_clear = terminal;
      default: timer_clear = 1'b0;
    endcase
  end

  frame_timer #(
    .TICK_W      (TICK_W),
    .FRAME_TICKS (FRAME_TICKS)
  ) u_frame_timer (
    .clock    (clock),
    .reset    (reset),
    .clear    (timer_clear),
    .enable   (timer_en),
    .tick     (tick_dbg),
    .terminal (terminal)
  );

  // Sequencer FSM with the layer index, frame counter and sticky overrun flag
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state       <= S_IDLE;
      layer_sel   <= '0;
      frame_count <= '0;
      overrun     <= 1'b0;
    end else begin
      case (state)
        S_IDLE: if (start) state <= S_ARM;
        S_ARM: if (!start) state <= S_CLEAR;
        S_CLEAR: if (clear_done) state <= S_UPDATE;
        S_UPDATE: begin
          if (finish_game) begin
            state <= S_END;
          end else begin
            state       <= S_DRAW;
            layer_sel   <= '0;
            frame_count <= frame_count + FRAME_W'(1);
          end
        end
        S_DRAW: begin
          if (draw_done) begin
            if (!last_layer) begin
              layer_sel <= layer_sel + LSW'(1);
            end else if (terminal) begin
              // Drawing used up the whole frame: go straight to the next update
              overrun <= 1'b1;
              state   <= S_UPDATE;
            end else begin
              state <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          // Frame boundary beats a coincident pause request
          if (terminal) state <= S_UPDATE;
          else if (pause_req) state <= S_PAUSE;
        end
        S_PAUSE: if (pause_req) state <= S_WAIT;
        S_END: begin
          if (start) begin
            state       <= S_ARM;
            overrun     <= 1'b0;
            frame_count <= '0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Moore decode of the state register; draw_layer follows the registered index
  always_comb begin
    update     = (state == S_UPDATE);
    clear      = (state == S_CLEAR);
    plot       = (state == S_CLEAR) || (state == S_DRAW);
    paused     = (state == S_PAUSE);
    game_over  = (state == S_END);
    draw_layer = '0;
    if (state == S_DRAW) draw_layer = N_LAYERS'(1) << layer_sel;
  end

  assign state_dbg = state;

endmodule
